exe_stage_module: RTL and testbench
===================================

EXE_STAGE_MODULE -- requirements
Module: exe_stage_module

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, synchronous active-high.
REQ-002 SHALL accept decode-register inputs:
- pc_in 32
- mem_read_en_in 1, mem_write_en_in 1, wb_enable_in 1
- immediate_in 1, branch_taken_in 1, status_write_enable_in 1
- execute_command_in 4
- reg_file_in1 32, reg_file_in2 32
- dest_reg_in 4, signed_immediate_in 24, shift_operand_in 12
- src1_addr_in 4, src2_addr_in 4
REQ-003 SHALL accept freeze in 1, which holds every register in this block.
REQ-004 SHALL accept forwarding inputs: mem_fwd_en 1, mem_fwd_dest 4, mem_fwd_value 32, wb_fwd_en 1, wb_fwd_dest 4, wb_fwd_value 32.
REQ-005 SHALL provide combinational outputs: branch_taken_out 1, branch_address_out 32.
REQ-006 SHALL provide registered outputs: status_reg_out 4 (N,Z,C,V in bits 3..0), mem_read_en_out 1, mem_write_en_out 1, wb_enable_out 1, alu_result_out 32, store_value_out 32, dest_reg_out 4.

Function
REQ-007 Val2 SHALL be formed as follows:
- mem_read_en_in or mem_write_en_in: zero-extended shift_operand_in[11:0].
- else immediate_in: shift_operand_in[7:0] rotated right by 2*shift_operand_in[11:8].
- else: operand2 shifted by shift_operand_in[11:7] using type [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-008 ALU ops SHALL be: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC (+C), 0100 SUB, 0101 SBC (-~C), 0110 AND, 0111 ORR, 1000 EOR; other codes give result 0 with flags unchanged.
REQ-009 N SHALL be result[31] and Z SHALL be (result==0); C and V SHALL come from 33-bit add/sub for arithmetic ops; logical ops SHALL keep the previous C and V.
REQ-010 branch_address_out SHALL equal pc_in + (sign-extended signed_immediate_in << 2), mod 2^32, in the same cycle.
REQ-011 branch_taken_out SHALL equal branch_taken_in with zero latency.
REQ-012 status_reg_out SHALL load the ALU flags on the rising edge when status_write_enable_in=1 and freeze=0; otherwise it SHALL hold.
REQ-013 The stage register SHALL capture control, result, Val1/Val2-side store value and dest_reg_in on every rising edge with freeze=0, giving 1-cycle latency; with freeze=1 all outputs SHALL hold.
REQ-014 store_value_out SHALL be the post-forwarding operand-2 value, unshifted.

Reset
REQ-015 With rst=1 at a rising edge, all registered outputs SHALL become 0, including status_reg_out.
REQ-016 rst SHALL take priority over freeze, including during a frozen operation.

Configuration
REQ-017 When FORWARDING_EN is defined, each operand SHALL be selected in priority order:
- MEM forward when mem_fwd_en=1 and mem_fwd_dest matches the operand's source address;
- else WB forward when wb_fwd_en=1 and wb_fwd_dest matches;
- else the register-file value.
When a source matches both MEM and WB, MEM SHALL win.
REQ-018 When FORWARDING_EN is undefined, operands SHALL always be reg_file_in1/reg_file_in2, and the forwarding inputs SHALL be ignored.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADD, reg_file_in1=0xFFFFFFFF, immediate 0x01, status_write_enable_in=1 -> next cycle alu_result_out=0, status_reg_out=0110.
- SUB, 0x80000000 - register 1 with LSL 0 -> result 0x7FFFFFFF, status_reg_out=0011.
- Immediate 0xFF with rotate 4 -> Val2=0xFF000000; MOV -> alu_result_out=0xFF000000.
- Branch: pc_in=0x100, signed_immediate_in=0xFFFFFE -> branch_address_out=0xF8 in the same cycle.
- FORWARDING_EN defined, src1_addr_in=3, mem_fwd_dest=3 and wb_fwd_dest=3 with values 5 and 9, ADD immediate 1 -> result 6; FORWARDING_EN undefined -> reg_file_in1+1.
- freeze=1 for 3 cycles with changing inputs -> outputs constant; rst asserted during freeze -> all outputs 0 next edge.

Source files
------------

// File: rtl/exe_stage_module.sv
// rtl/exe_stage_module.sv - execute stage: operand select, Val2 generation, ALU, flags and stage register
//
// Optional feature macro: FORWARDING_EN (MEM/WB operand forwarding; MEM wins over WB).
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   freeze                         holds every register in the block
//   pc_in, signed_immediate_in     branch target inputs
//   *_en_in, immediate_in, ...     decode-register control inputs
//   execute_command_in             ALU opcode
//   reg_file_in1/2, src1/2_addr_in operand values and their source register numbers
//   shift_operand_in               immediate / shifter operand field
//   mem_fwd_*, wb_fwd_*            forwarding sources
//   branch_taken_out, branch_address_out   combinational branch outputs
//   status_reg_out (N,Z,C,V), mem_*_out, wb_enable_out,
//   alu_result_out, store_value_out, dest_reg_out          registered outputs
module exe_stage_module (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic        wb_enable_in,
  input  logic        immediate_in,
  input  logic        branch_taken_in,
  input  logic        status_write_enable_in,
  input  logic [3:0]  execute_command_in,
  input  logic [31:0] reg_file_in1,
  input  logic [31:0] reg_file_in2,
  input  logic [3:0]  dest_reg_in,
  input  logic [23:0] signed_immediate_in,
  input  logic [11:0] shift_operand_in,
  input  logic [3:0]  src1_addr_in,
  input  logic [3:0]  src2_addr_in,
  input  logic        mem_fwd_en,
  input  logic [3:0]  mem_fwd_dest,
  input  logic [31:0] mem_fwd_value,
  input  logic        wb_fwd_en,
  input  logic [3:0]  wb_fwd_dest,
  input  logic [31:0] wb_fwd_value,
  output logic        branch_taken_out,
  output logic [31:0] branch_address_out,
  output logic [3:0]  status_reg_out,
  output logic        mem_read_en_out,
  output logic        mem_write_en_out,
  output logic        wb_enable_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_value_out,
  output logic [3:0]  dest_reg_out
);

  logic [3:0]  status_reg_q, status_reg_d;
  logic        mem_read_en_q, mem_read_en_d;
  logic        mem_write_en_q, mem_write_en_d;
  logic        wb_enable_q, wb_enable_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_value_q, store_value_d;
  logic [3:0]  dest_reg_q, dest_reg_d;

  logic [31:0] val1, op2, val2, result;
  logic [3:0]  flags;

  assign branch_taken_out   = branch_taken_in;
  assign branch_address_out = pc_in + {{6{signed_immediate_in[23]}}, signed_immediate_in, 2'b00};

`ifdef FORWARDING_EN
  always_comb begin
    val1 = reg_file_in1;
    if (mem_fwd_en && (mem_fwd_dest == src1_addr_in))     val1 = mem_fwd_value;
    else if (wb_fwd_en && (wb_fwd_dest == src1_addr_in))  val1 = wb_fwd_value;
    op2 = reg_file_in2;
    if (mem_fwd_en && (mem_fwd_dest == src2_addr_in))     op2 = mem_fwd_value;
    else if (wb_fwd_en && (wb_fwd_dest == src2_addr_in))  op2 = wb_fwd_value;
  end
`else
  assign val1 = reg_file_in1;
  assign op2  = reg_file_in2;
  wire unused_fwd = ^{src1_addr_in, src2_addr_in, mem_fwd_en, mem_fwd_dest, mem_fwd_value,
                      wb_fwd_en, wb_fwd_dest, wb_fwd_value};
`endif

  // Rotations use a doubled word so a right shift brings the low bits round to the top.
  logic [63:0] imm_wide, reg_wide;
  logic [4:0]  sh_amt;
  always_comb begin
    sh_amt   = shift_operand_in[11:7];
    imm_wide = {24'd0, shift_operand_in[7:0], 24'd0, shift_operand_in[7:0]}
               >> {shift_operand_in[11:8], 1'b0};
    reg_wide = {op2, op2} >> sh_amt;
    if (mem_read_en_in || mem_write_en_in) begin
      val2 = {20'd0, shift_operand_in};
    end else if (immediate_in) begin
      val2 = imm_wide[31:0];
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   val2 = op2 << sh_amt;
        2'b01:   val2 = op2 >> sh_amt;
        2'b10:   val2 = $unsigned($signed(op2) >>> sh_amt);
        default: val2 = reg_wide[31:0];
      endcase
    end
  end

  // Subtraction is a + ~b + 1 so that C reads as "no borrow"; SBC substitutes C for the +1.
  logic [32:0] sum;
  logic        arith, is_sub, valid, ovf;
  always_comb begin
    sum    = 33'd0;
    arith  = 1'b0;
    is_sub = 1'b0;
    valid  = 1'b1;
    result = 32'd0;
    case (execute_command_in)
      4'b0001: result = val2;
      4'b1001: result = ~val2;
      4'b0010: begin sum = {1'b0, val1} + {1'b0, val2}; arith = 1'b1; end
      4'b0011: begin sum = {1'b0, val1} + {1'b0, val2} + {32'd0, status_reg_q[1]}; arith = 1'b1; end
      4'b0100: begin sum = {1'b0, val1} + {1'b0, ~val2} + 33'd1; arith = 1'b1; is_sub = 1'b1; end
      4'b0101: begin sum = {1'b0, val1} + {1'b0, ~val2} + {32'd0, status_reg_q[1]}; arith = 1'b1; is_sub = 1'b1; end
      4'b0110: result = val1 & val2;
      4'b0111: result = val1 | val2;
      4'b1000: result = val1 ^ val2;
      default: valid = 1'b0;
    endcase
    if (arith) result = sum[31:0];
    ovf = (is_sub ? (val1[31] != val2[31]) : (val1[31] == val2[31])) && (result[31] != val1[31]);
    if (!valid)     flags = status_reg_q;
    else if (arith) flags = {result[31], result == 32'd0, sum[32], ovf};
    else            flags = {result[31], result == 32'd0, status_reg_q[1:0]};
  end

  always_comb begin
    status_reg_d   = status_reg_q;
    mem_read_en_d  = mem_read_en_q;
    mem_write_en_d = mem_write_en_q;
    wb_enable_d    = wb_enable_q;
    alu_result_d   = alu_result_q;
    store_value_d  = store_value_q;
    dest_reg_d     = dest_reg_q;
    if (!freeze) begin
      if (status_write_enable_in) status_reg_d = flags;
      mem_read_en_d  = mem_read_en_in;
      mem_write_en_d = mem_write_en_in;
      wb_enable_d    = wb_enable_in;
      alu_result_d   = result;
      store_value_d  = op2;
      dest_reg_d     = dest_reg_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg_q   <= 4'd0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      wb_enable_q    <= 1'b0;
      alu_result_q   <= 32'd0;
      store_value_q  <= 32'd0;
      dest_reg_q     <= 4'd0;
    end else begin
      status_reg_q   <= status_reg_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      wb_enable_q    <= wb_enable_d;
      alu_result_q   <= alu_result_d;
      store_value_q  <= store_value_d;
      dest_reg_q     <= dest_reg_d;
    end
  end

  assign status_reg_out   = status_reg_q;
  assign mem_read_en_out  = mem_read_en_q;
  assign mem_write_en_out = mem_write_en_q;
  assign wb_enable_out    = wb_enable_q;
  assign alu_result_out   = alu_result_q;
  assign store_value_out  = store_value_q;
  assign dest_reg_out     = dest_reg_q;

endmodule

// File: tb/tb_exe_stage_module.sv
// tb/tb_exe_stage_module.sv - self-checking bench for exe_stage_module
module tb_exe_stage_module;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, freeze;
  logic [31:0] pc_in;
  logic        mem_read_en_in, mem_write_en_in, wb_enable_in;
  logic        immediate_in, branch_taken_in, status_write_enable_in;
  logic [3:0]  execute_command_in;
  logic [31:0] reg_file_in1, reg_file_in2;
  logic [3:0]  dest_reg_in;
  logic [23:0] signed_immediate_in;
  logic [11:0] shift_operand_in;
  logic [3:0]  src1_addr_in, src2_addr_in;
  logic        mem_fwd_en, wb_fwd_en;
  logic [3:0]  mem_fwd_dest, wb_fwd_dest;
  logic [31:0] mem_fwd_value, wb_fwd_value;
  logic        branch_taken_out;
  logic [31:0] branch_address_out;
  logic [3:0]  status_reg_out;
  logic        mem_read_en_out, mem_write_en_out, wb_enable_out;
  logic [31:0] alu_result_out, store_value_out;
  logic [3:0]  dest_reg_out;

  exe_stage_module dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in), .wb_enable_in(wb_enable_in),
    .immediate_in(immediate_in), .branch_taken_in(branch_taken_in),
    .status_write_enable_in(status_write_enable_in), .execute_command_in(execute_command_in),
    .reg_file_in1(reg_file_in1), .reg_file_in2(reg_file_in2), .dest_reg_in(dest_reg_in),
    .signed_immediate_in(signed_immediate_in), .shift_operand_in(shift_operand_in),
    .src1_addr_in(src1_addr_in), .src2_addr_in(src2_addr_in),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_dest(mem_fwd_dest), .mem_fwd_value(mem_fwd_value),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_value(wb_fwd_value),
    .branch_taken_out(branch_taken_out), .branch_address_out(branch_address_out),
    .status_reg_out(status_reg_out), .mem_read_en_out(mem_read_en_out),
    .mem_write_en_out(mem_write_en_out), .wb_enable_out(wb_enable_out),
    .alu_result_out(alu_result_out), .store_value_out(store_value_out), .dest_reg_out(dest_reg_out)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [3:0]  m_status = 4'd0;
  logic        m_mr = 1'b0, m_mw = 1'b0, m_wb = 1'b0;
  logic [31:0] m_res = 32'd0, m_store = 32'd0;
  logic [3:0]  m_dest = 4'd0;

  wire [74:0] dut_regs = {status_reg_out, mem_read_en_out, mem_write_en_out, wb_enable_out,
                          alu_result_out, store_value_out, dest_reg_out};
  wire [74:0] m_regs   = {m_status, m_mr, m_mw, m_wb, m_res, m_store, m_dest};

  function automatic logic [31:0] m_operand(input logic [3:0] src, input logic [31:0] rf);
`ifdef FORWARDING_EN
    if (mem_fwd_en && mem_fwd_dest == src) return mem_fwd_value;
    if (wb_fwd_en && wb_fwd_dest == src) return wb_fwd_value;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [31:0] y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
    return y;
  endfunction

  function automatic logic [31:0] m_val2(input logic [31:0] op2);
    longint unsigned u;
    int amt;
    if (mem_read_en_in || mem_write_en_in) return {20'd0, shift_operand_in};
    if (immediate_in) return m_rotr({24'd0, shift_operand_in[7:0]}, 2 * int'(shift_operand_in[11:8]));
    amt = int'(shift_operand_in[11:7]);
    u = op2;
    case (shift_operand_in[6:5])
      2'b00:   return 32'(u * (64'd1 << amt));
      2'b01:   return op2 / (32'd1 << amt);
      2'b10:   return op2[31] ? ~((~op2) / (32'd1 << amt)) : op2 / (32'd1 << amt);
      default: return m_rotr(op2, amt);
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] a, b, v2, res;
    longint unsigned ua, ub, cin;
    longint sa, sb, ss;
    logic c, v, valid;
    if (rst) begin
      m_status = 0; m_mr = 0; m_mw = 0; m_wb = 0; m_res = 0; m_store = 0; m_dest = 0;
      return;
    end
    if (freeze) return;
    a  = m_operand(src1_addr_in, reg_file_in1);
    b  = m_operand(src2_addr_in, reg_file_in2);
    v2 = m_val2(b);
    ua = a; ub = v2; sa = $signed(a); sb = $signed(v2);
    cin = m_status[1];
    c = m_status[1]; v = m_status[0]; valid = 1'b1; res = 32'd0; ss = 0;
    case (execute_command_in)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        if (execute_command_in == 4'd2) cin = 0;
        res = 32'(ua + ub + cin);
        c   = (ua + ub + cin) >= 64'h1_0000_0000;
        ss  = sa + sb + longint'(cin);
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        cin = (execute_command_in == 4'd4) ? 64'd0 : 64'd1 - cin;  // borrow
        res = 32'(ua - ub - cin);
        c   = ua >= ub + cin;
        ss  = sa - sb - longint'(cin);
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd6: res = a & v2;
      4'd7: res = a | v2;
      4'd8: res = a ^ v2;
      default: valid = 1'b0;
    endcase
    if (status_write_enable_in && valid) m_status = {res[31], res == 32'd0, c, v};
    m_mr = mem_read_en_in; m_mw = mem_write_en_in; m_wb = wb_enable_in;
    m_res = res; m_store = b; m_dest = dest_reg_in;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; freeze = 0; pc_in = 0; mem_read_en_in = 0; mem_write_en_in = 0; wb_enable_in = 0;
    immediate_in = 0; branch_taken_in = 0; status_write_enable_in = 0; execute_command_in = 0;
    reg_file_in1 = 0; reg_file_in2 = 0; dest_reg_in = 0; signed_immediate_in = 0;
    shift_operand_in = 0; src1_addr_in = 0; src2_addr_in = 0;
    mem_fwd_en = 0; mem_fwd_dest = 0; mem_fwd_value = 0; wb_fwd_en = 0; wb_fwd_dest = 0; wb_fwd_value = 0;
  endtask

  task automatic rand_inputs();
    pc_in = $urandom; mem_read_en_in = ($urandom_range(0, 5) == 0); mem_write_en_in = ($urandom_range(0, 5) == 0);
    wb_enable_in = $urandom; immediate_in = $urandom; branch_taken_in = $urandom;
    status_write_enable_in = $urandom; execute_command_in = 4'($urandom);
    reg_file_in1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    reg_file_in2 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
    dest_reg_in = 4'($urandom); signed_immediate_in = 24'($urandom); shift_operand_in = 12'($urandom);
    src1_addr_in = 4'($urandom_range(0, 3)); src2_addr_in = 4'($urandom_range(0, 3));
    mem_fwd_en = $urandom; mem_fwd_dest = 4'($urandom_range(0, 3)); mem_fwd_value = $urandom;
    wb_fwd_en = $urandom; wb_fwd_dest = 4'($urandom_range(0, 3)); wb_fwd_value = $urandom;
  endtask

  task automatic test_reset();
    rand_inputs();
    rst = 1; freeze = 0;
    tick();
    tests_run++;
    if (dut_regs !== 75'd0) begin
      tests_failed++; $display("FAIL reset_regs got %h expected 0", dut_regs);
    end
    rst = 0;
  endtask

  task automatic test_add_carry();
    clear_inputs();
    execute_command_in = 4'b0010; reg_file_in1 = 32'hFFFF_FFFF; immediate_in = 1;
    shift_operand_in = 12'h001; status_write_enable_in = 1;
    tick();
    tests_run++;
    if ({alu_result_out, status_reg_out} !== {32'd0, 4'b0110}) begin
      tests_failed++; $display("FAIL add_carry got %h/%b expected 0/0110", alu_result_out, status_reg_out);
    end
  endtask

  task automatic test_sub_overflow();
    clear_inputs();
    execute_command_in = 4'b0100; reg_file_in1 = 32'h8000_0000; reg_file_in2 = 32'd1;
    status_write_enable_in = 1;
    tick();
    tests_run++;
    if ({alu_result_out, status_reg_out} !== {32'h7FFF_FFFF, 4'b0011}) begin
      tests_failed++; $display("FAIL sub_overflow got %h/%b expected 7fffffff/0011", alu_result_out, status_reg_out);
    end
  endtask

  task automatic test_imm_rotate();
    clear_inputs();
    execute_command_in = 4'b0001; immediate_in = 1; shift_operand_in = 12'h4FF;
    tick();
    tests_run++;
    if (alu_result_out !== 32'hFF00_0000) begin
      tests_failed++; $display("FAIL imm_rotate got %h expected ff000000", alu_result_out);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    pc_in = 32'h100; signed_immediate_in = 24'hFFFFFE; branch_taken_in = 1;
    #1;
    tests_run++;
    if ({branch_taken_out, branch_address_out} !== {1'b1, 32'hF8}) begin
      tests_failed++; $display("FAIL branch got %b/%h expected 1/f8", branch_taken_out, branch_address_out);
    end
    branch_taken_in = 0; pc_in = 32'hFFFF_FFF0; signed_immediate_in = 24'h000008;
    #1;
    tests_run++;
    if ({branch_taken_out, branch_address_out} !== {1'b0, 32'h10}) begin
      tests_failed++; $display("FAIL branch_wrap got %b/%h expected 0/10", branch_taken_out, branch_address_out);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp;
    clear_inputs();
    execute_command_in = 4'b0010; immediate_in = 1; shift_operand_in = 12'h001;
    reg_file_in1 = 32'h0000_1234; src1_addr_in = 3;
    mem_fwd_en = 1; mem_fwd_dest = 3; mem_fwd_value = 5;
    wb_fwd_en = 1; wb_fwd_dest = 3; wb_fwd_value = 9;
`ifdef FORWARDING_EN
    exp = 32'd6;
`else
    exp = 32'h0000_1235;
`endif
    tick();
    tests_run++;
    if (alu_result_out !== exp) begin
      tests_failed++; $display("FAIL fwd_mem_priority got %h expected %h", alu_result_out, exp);
    end
    mem_fwd_dest = 2;
`ifdef FORWARDING_EN
    exp = 32'd10;
`endif
    tick();
    tests_run++;
    if (alu_result_out !== exp) begin
      tests_failed++; $display("FAIL fwd_wb got %h expected %h", alu_result_out, exp);
    end
  endtask

  task automatic test_freeze();
    logic [74:0] snap;
    rand_inputs(); rst = 0; freeze = 0;
    execute_command_in = 4'b0010; status_write_enable_in = 1; reg_file_in1 = 32'h7FFF_FFFF;
    tick();
    snap = dut_regs;
    tests_run++;
    if (dut_regs !== m_regs) begin
      tests_failed++; $display("FAIL freeze_load got %h expected %h", dut_regs, m_regs);
    end
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); rst = 0; freeze = 1; status_write_enable_in = 1;
      tick();
      tests_run++;
      if (dut_regs !== snap || dut_regs !== m_regs) begin
        tests_failed++; $display("FAIL freeze_hold cycle %0d got %h expected %h", i, dut_regs, snap);
      end
    end
    rand_inputs(); rst = 1; freeze = 1;
    tick();
    tests_run++;
    if (dut_regs !== 75'd0) begin
      tests_failed++; $display("FAIL reset_in_freeze got %h expected 0", dut_regs);
    end
    rst = 0; freeze = 0;
  endtask

  task automatic test_random();
    logic [31:0] exp_addr;
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 40) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      #1;
      exp_addr = 32'(longint'(pc_in) + longint'($signed(signed_immediate_in)) * 4);
      tests_run++;
      if ({branch_taken_out, branch_address_out} !== {branch_taken_in, exp_addr}) begin
        tests_failed++; $display("FAIL rand_branch %0d got %b/%h expected %b/%h", i,
                                 branch_taken_out, branch_address_out, branch_taken_in, exp_addr);
      end
      tick();
      tests_run++;
      if (dut_regs !== m_regs) begin
        tests_failed++; $display("FAIL rand_regs %0d got %h expected %h", i, dut_regs, m_regs);
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    test_reset();
    test_add_carry();
    test_sub_overflow();
    test_imm_rotate();
    test_branch();
    test_forwarding();
    test_freeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
